// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline stage with optional skid entry, flush and saturating stall counter
module pipe_stage_elastic #(
  parameter int WIDTH = 32,
  parameter int SKID = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc, pop;
  assign out_valid = state_q != EMPTY;
  assign in_ready = SKID != 0 ? state_q != TWO : state_q == EMPTY || out_ready;
  assign out_data = main_q;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (acc ? ONE : EMPTY) :
              state_q == ONE ? (acc & ~pop ? TWO : ~acc & pop ? EMPTY : ONE) :
              (pop ? ONE : TWO);
    main_d = flush ? BUBBLE :
             (state_q == EMPTY || state_q == ONE && pop) && acc ? in_data :
             state_q == ONE && pop ? BUBBLE :
             state_q == TWO && pop ? skid_q : main_q;
    skid_d = flush ? BUBBLE :
             state_q == ONE && acc && !pop ? in_data :
             state_q == TWO && pop ? BUBBLE : skid_q;
    cnt_d = out_valid && !out_ready && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench running a skid (CNT_W=4) and a no-skid lane on shared stimulus
module tb_pipe_stage_elastic;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [7:0] in_data = '0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int S = g == 1 ? 1 : 0;
    localparam int CW = g == 1 ? 4 : 16;
    logic ir, ov;
    logic [7:0] od;
    logic [1:0] occ;
    logic [CW-1:0] sc;
    logic [7:0] sb[$];
    int stall = 0;
    bit init = 0;
    pipe_stage_elastic #(.WIDTH(8), .SKID(S), .BUBBLE(8'h00), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir),
      .in_data(in_data), .out_valid(ov), .out_ready(out_ready), .out_data(od),
      .occupancy(occ), .stall_cnt(sc)
    );
    always @(negedge clk) begin
      bit ev, er;
      ev = sb.size() > 0;
      er = S != 0 ? sb.size() < 2 : sb.size() == 0 || out_ready;
      if (init) begin
        chk($sformatf("L%0d out_valid", g), ov, ev);
        chk($sformatf("L%0d out_data", g), od, ev ? sb[0] : 8'h00);
        chk($sformatf("L%0d occupancy", g), occ, sb.size());
        chk($sformatf("L%0d in_ready", g), ir, er);
        chk($sformatf("L%0d stall_cnt", g), sc, stall);
      end
      if (rst) begin
        sb.delete();
        stall = 0;
        init = 1;
      end else if (init) begin
        if (ev && !out_ready && stall < (1 << CW) - 1) stall++;
        if (ov && out_ready) begin
          if (ev) chk($sformatf("L%0d popped beat", g), od, sb.pop_front());
          else chk($sformatf("L%0d spurious beat", g), ov, 0);
        end
        if (flush) sb.delete();
        else if (in_valid && er) sb.push_back(in_data);
      end
    end
  end
  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    drive(1, 8'h11, 1, 0);
    drive(0, 8'h00, 1, 0);
    for (int i = 1; i <= 8; i++) drive(1, 8'(i), 1, 0);
    drive(0, 8'h00, 1, 0);
    drive(1, 8'h0A, 0, 0);
    drive(1, 8'h0B, 0, 0);
    repeat (3) drive(0, 8'h00, 0, 0);
    repeat (3) drive(0, 8'h00, 1, 0);
    drive(1, 8'h0A, 0, 0);
    drive(1, 8'h0B, 0, 0);
    drive(1, 8'h0C, 0, 1);
    repeat (2) drive(0, 8'h00, 1, 0);
    drive(1, 8'h55, 0, 0);
    repeat (20) drive(0, 8'h00, 0, 0);
    chk("L1 saturated stall_cnt", 32'(lane[1].sc), 15);
    rst = 1;
    drive(0, 8'h00, 1, 0);
    rst = 0;
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), i < 150 ? 1'(i % 2) : 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0));
    repeat (4) drive(0, 8'h00, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
